// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_skid : elastic 2-entry skid pipeline stage with flush and perf counters
// Revision 1.0
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W     = 160,
  parameter int CTRL_W     = 8,
  parameter int CNT_W      = 16,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0]       c_EMPTY   = 2'd0;
  localparam logic [1:0]       c_ONE     = 2'd1;
  localparam logic [1:0]       c_FULL    = 2'd2;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_occ;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_head_data;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_head_ctrl;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_occ_nxt;
  logic [DATA_W-1:0] w_head_data_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CTRL_W-1:0] w_head_ctrl_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic              w_stall_inc;
  logic              w_bubble_inc;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  always_comb begin
    w_occ_nxt       = r_occ;
    w_head_data_nxt = r_head_data;
    w_skid_data_nxt = r_skid_data;
    w_head_ctrl_nxt = r_head_ctrl;
    w_skid_ctrl_nxt = r_skid_ctrl;
    if (flush) begin
      // A pop in this cycle has already been consumed downstream; a push is dropped.
      w_occ_nxt       = c_EMPTY;
      w_head_ctrl_nxt = '0;
      w_skid_ctrl_nxt = '0;
      if (CLEAR_DATA) begin
        w_head_data_nxt = '0;
        w_skid_data_nxt = '0;
      end
    end else begin
      case (r_occ)
        c_EMPTY: begin
          if (w_push) begin
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
            w_occ_nxt       = c_ONE;
          end
        end
        c_ONE: begin
          if (w_push && w_pop) begin
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
          end else if (w_push) begin
            w_skid_data_nxt = in_data;
            w_skid_ctrl_nxt = in_ctrl;
            w_occ_nxt       = c_FULL;
          end else if (w_pop) begin
            w_occ_nxt       = c_EMPTY;
          end
        end
        c_FULL: begin
          if (w_pop) begin
            w_head_data_nxt = r_skid_data;
            w_head_ctrl_nxt = r_skid_ctrl;
            w_occ_nxt       = c_ONE;
          end
        end
        default: begin
          w_occ_nxt = c_EMPTY;
        end
      endcase
    end
  end

  // in_ready is derived from next occupancy so it stays a pure register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ       <= c_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_head_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_occ       <= w_occ_nxt;
      r_out_valid <= (w_occ_nxt != c_EMPTY);
      r_in_ready  <= (w_occ_nxt != c_FULL);
      r_head_ctrl <= w_head_ctrl_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  generate
    if (CLEAR_DATA) begin : g_data_clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_head_data <= '0;
          r_skid_data <= '0;
        end else begin
          r_head_data <= w_head_data_nxt;
          r_skid_data <= w_skid_data_nxt;
        end
      end
    end else begin : g_data_hold
      always_ff @(posedge clk) begin
        r_head_data <= w_head_data_nxt;
        r_skid_data <= w_skid_data_nxt;
      end
    end
  endgenerate

  assign w_stall_inc  = r_out_valid & ~out_ready;
  assign w_bubble_inc = ~r_out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (w_bubble_inc && (r_bubble_cnt != c_CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_head_data;
  assign out_ctrl   = r_out_valid ? r_head_ctrl : '0;
  assign occupancy  = r_occ;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid : scoreboard bench for pipe_stage_skid (CNT_W=4, CLEAR_DATA=1)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic          cnt_clr;
  logic [NW-1:0] stall_cnt;
  logic [NW-1:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW+CW-1:0] exp_q[$];

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .CNT_W(NW), .CLEAR_DATA(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on the output side consumes one scoreboard entry.
  always @(negedge clk) begin : mon
    logic [DW+CW-1:0] e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pop: got %0h, expected no output", {out_data, out_ctrl});
        end else begin
          e = exp_q.pop_front();
          check("pop_payload", {out_data, out_ctrl}, e);
        end
      end
      if (!out_valid) check("bubble_ctrl_zero", out_ctrl, 0);
    end
  end

  // One clock of stimulus; the expected entry is queued only if the push is accepted.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic ordy, input logic fl, input logic clr);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    if (v && in_ready && !fl) exp_q.push_back({d, c});
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_bubble", bubble_cnt, 0);
    @(posedge clk); #1;
    check("rst_in_ready_low", in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_occ", occupancy, 0);

    // Streaming A..J with out_ready held high
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'h0000_00A0 + DW'(i), 8'h10 + CW'(i), 1'b1, 1'b0, 1'b0);
      check("stream_occ", occupancy, 1);
      check("stream_head", out_data, 32'h0000_00A0 + i);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("stream_drain_occ", occupancy, 0);
    check("stream_bubble", bubble_cnt, 1);
    check("stream_stall", stall_cnt, 0);

    // Backpressure: B0 in head, B1 in skid, B2 held upstream
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h0000_0B00, 8'h21, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0B01, 8'h22, 1'b0, 1'b0, 1'b0);
    check("bp_occ_full", occupancy, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_head", out_data, 32'h0000_0B00);
    cyc(1'b1, 32'h0000_0B02, 8'h23, 1'b0, 1'b0, 1'b0);
    check("bp_stall", stall_cnt, 2);
    check("bp_still_full", occupancy, 2);
    cyc(1'b1, 32'h0000_0B02, 8'h23, 1'b1, 1'b0, 1'b0);
    check("bp_recover_occ", occupancy, 1);
    check("bp_recover_ready", in_ready, 1);
    cyc(1'b1, 32'h0000_0B02, 8'h23, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("bp_drained_occ", occupancy, 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Flush from FULL with a pop in the same cycle
    cyc(1'b1, 32'h0000_0F00, 8'hC3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0F01, 8'hC4, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0F0D, 8'hC5, 1'b1, 1'b1, 1'b0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_ctrl", out_ctrl, 0);
    check("flush_out_data", out_data, 0);
    check("flush_occ", occupancy, 0);
    check("flush_in_ready", in_ready, 1);
    // Flush from ONE drops the concurrent push
    cyc(1'b1, 32'h0000_0F03, 8'hC6, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0F04, 8'hC7, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("flush_one_occ", occupancy, 0);
    check("flush_one_valid", out_valid, 0);

    // Control bits offered without in_valid never appear
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0000_DEAD, 8'hFF, 1'b1, 1'b0, 1'b0);
      check("bubble_ctrl", out_ctrl, 0);
    end

    // Stall counter saturation and clear
    cyc(1'b1, 32'h0000_00E0, 8'h55, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("stall_reach_max", stall_cnt, 15);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("stall_saturate", stall_cnt, 15);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("stall_clr", stall_cnt, 0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("stall_after_clr", stall_cnt, 1);
    check("bubble_after_clr", bubble_cnt, 0);

    // Asynchronous reset while FULL
    cyc(1'b1, 32'h0000_00E1, 8'h56, 1'b0, 1'b0, 1'b0);
    check("pre_rst_occ", occupancy, 2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_occ", occupancy, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_ctrl", out_ctrl, 0);
    check("async_rst_stall", stall_cnt, 0);
    check("async_rst_in_ready", in_ready, 0);
    exp_q.delete();
    in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("release_in_ready", in_ready, 1);
    check("release_stall", stall_cnt, 0);
    check("release_bubble", bubble_cnt, 0);
    check("release_occ", occupancy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
